// File: rtl/if_pkg.sv
// Shared types for the instruction fetch stage: FSM states, IF/ID payload, reset defaults.
package if_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'hBFC0_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DROP
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            adel;
    } if_id_t;

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bus bundle: SRAM-like instruction port, IF->ID payload, redirect and flush inputs.
interface if_fetch_if;
    import if_pkg::*;

    logic            inst_req_o;
    logic [XLEN-1:0] inst_addr_o;
    logic            inst_addr_ok_i;
    logic            inst_data_ok_i;
    logic [XLEN-1:0] inst_rdata_i;
    logic            id_stall_i;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            exc_flush_i;
    logic [XLEN-1:0] exc_pc_i;
    logic            id_valid_o;
    logic [XLEN-1:0] id_instr_o;
    logic [XLEN-1:0] id_pc_o;
    logic [XLEN-1:0] id_pc4_o;
    logic            id_adel_o;
    logic            if_stall_o;

    modport master (
        output inst_req_o, inst_addr_o,
        input  inst_addr_ok_i, inst_data_ok_i, inst_rdata_i,
        input  id_stall_i, redirect_i, redirect_pc_i, exc_flush_i, exc_pc_i,
        output id_valid_o, id_instr_o, id_pc_o, id_pc4_o, id_adel_o, if_stall_o
    );

    modport slave (
        input  inst_req_o, inst_addr_o,
        output inst_addr_ok_i, inst_data_ok_i, inst_rdata_i,
        output id_stall_i, redirect_i, redirect_pc_i, exc_flush_i, exc_pc_i,
        input  id_valid_o, id_instr_o, id_pc_o, id_pc4_o, id_adel_o, if_stall_o
    );

endinterface

// File: rtl/if_inst_buffer.sv
// One-entry skid buffer holding a fetch response while decode is stalled.
module if_inst_buffer
    import if_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   load,
    input  logic   drain,
    input  logic   clear,
    input  if_id_t din,
    output if_id_t dout,
    output logic   valid
);

    // clear wins over load so a flush always empties the entry
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Fetch stage: owns the PC, one-outstanding SRAM-like requests, IF/ID registers and delay-slot redirects.
// Optional IF_ADDR_EXC_EN: a misaligned PC raises id_adel_o instead of issuing a request.
module if_fetch
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    if_fetch_if.master bus
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            pend_valid_q, pend_valid_d;
    logic            id_valid_q, id_valid_d;
    if_id_t          id_q, id_d;
    logic [XLEN-1:0] id_pc4_q, id_pc4_d;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] fetch_addr;
    logic            misaligned;
    logic            buf_load, buf_drain, buf_clear, buf_valid;
    if_id_t          buf_din, buf_dout;
    logic            redir;

`ifdef IF_ADDR_EXC_EN
    assign misaligned = |pc_q[1:0];
    assign fetch_addr = pc_q;
`else
    assign misaligned = 1'b0;
    assign fetch_addr = {pc_q[XLEN-1:2], 2'b00};
`endif

    assign redir   = bus.redirect_i && !bus.id_stall_i;
    assign buf_din = '{instr: bus.inst_rdata_i, pc: req_pc_q, adel: 1'b0};

    if_inst_buffer u_buf (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .load  (buf_load),
        .drain (buf_drain),
        .clear (buf_clear),
        .din   (buf_din),
        .dout  (buf_dout),
        .valid (buf_valid)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            pend_pc_q    <= '0;
            pend_valid_q <= 1'b0;
            id_valid_q   <= 1'b0;
            id_q         <= '{instr: NOP_INSTR, pc: '0, adel: 1'b0};
            id_pc4_q     <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            pend_pc_q    <= pend_pc_d;
            pend_valid_q <= pend_valid_d;
            id_valid_q   <= id_valid_d;
            id_q         <= id_d;
            id_pc4_q     <= id_pc4_d;
        end
    end

    // A redirect before the delay slot is accepted parks in the pending target;
    // once the slot is in flight the target goes straight into pc.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        pend_pc_d    = pend_pc_q;
        pend_valid_d = pend_valid_q;
        id_valid_d   = id_valid_q;
        id_d         = id_q;
        id_pc4_d     = id_pc4_q;
        buf_load     = 1'b0;
        buf_drain    = 1'b0;
        buf_clear    = 1'b0;
        next_pc      = pend_valid_q ? pend_pc_q : pc_q + XLEN'(4);

        if (!bus.id_stall_i) begin
            id_valid_d = 1'b0;
            id_d.instr = NOP_INSTR;
        end

        if (bus.exc_flush_i) begin
            pc_d         = bus.exc_pc_i;
            pend_valid_d = 1'b0;
            id_valid_d   = 1'b0;
            id_d         = '{instr: NOP_INSTR, pc: '0, adel: 1'b0};
            id_pc4_d     = '0;
            buf_clear    = 1'b1;
            case (state_q)
                WAIT, DROP: state_d = bus.inst_data_ok_i ? REQ : DROP;
                default:    state_d = REQ;
            endcase
        end else begin
            case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (misaligned) begin
                        if (!bus.id_stall_i) begin
                            id_valid_d = 1'b1;
                            id_d       = '{instr: NOP_INSTR, pc: pc_q, adel: 1'b1};
                            id_pc4_d   = pc_q + XLEN'(4);
                        end
                    end else if (bus.inst_addr_ok_i) begin
                        state_d      = WAIT;
                        req_pc_d     = fetch_addr;
                        pc_d         = redir ? bus.redirect_pc_i : next_pc;
                        pend_valid_d = 1'b0;
                    end else if (redir) begin
                        pend_valid_d = 1'b1;
                        pend_pc_d    = bus.redirect_pc_i;
                    end
                end
                WAIT: begin
                    if (redir) begin
                        pc_d = bus.redirect_pc_i;
                    end
                    if (bus.inst_data_ok_i) begin
                        if (!bus.id_stall_i) begin
                            id_valid_d = 1'b1;
                            id_d       = buf_din;
                            id_pc4_d   = req_pc_q + XLEN'(4);
                            state_d    = REQ;
                        end else begin
                            buf_load = 1'b1;
                            state_d  = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!bus.id_stall_i) begin
                        if (redir) begin
                            pc_d = bus.redirect_pc_i;
                        end
                        if (buf_valid) begin
                            id_valid_d = 1'b1;
                            id_d       = buf_dout;
                            id_pc4_d   = buf_dout.pc + XLEN'(4);
                        end
                        buf_drain = 1'b1;
                        state_d   = REQ;
                    end
                end
                DROP: begin
                    if (bus.inst_data_ok_i) begin
                        state_d = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.inst_req_o  = (state_q == REQ) && !misaligned && !bus.exc_flush_i;
    assign bus.inst_addr_o = fetch_addr;
    assign bus.id_valid_o  = id_valid_q;
    assign bus.id_instr_o  = id_q.instr;
    assign bus.id_pc_o     = id_q.pc;
    assign bus.id_pc4_o    = id_pc4_q;
    assign bus.id_adel_o   = id_q.adel;
    assign bus.if_stall_o  = ((state_q == REQ) || (state_q == WAIT) || (state_q == DROP))
                             && !bus.exc_flush_i;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a small SRAM-like memory model and an accepted-address log.
module tb_if_fetch;
    import if_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    if_fetch_if mif ();

    if_fetch dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model state
    int          data_delay;
    int          addr_delay;
    int          dcnt;
    int          acnt;
    bit          busy;
    logic [31:0] cur_addr;
    bit          override_en;
    logic [31:0] override_data;
    logic [31:0] req_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] log_at(input int i);
        if (i < req_log.size()) return req_log[i];
        return 32'hDEAD_DEAD;
    endfunction

    // responds just after each falling edge, so it sees the inputs driven on that edge
    always @(negedge clk) begin
        #1;
        mif.inst_addr_ok_i = 1'b0;
        mif.inst_data_ok_i = 1'b0;
        if (!rst_n) begin
            busy = 1'b0;
            acnt = 0;
        end else if (busy) begin
            if (dcnt == 0) begin
                mif.inst_data_ok_i = 1'b1;
                mif.inst_rdata_i   = override_en ? override_data : mem_word(cur_addr);
                override_en        = 1'b0;
                busy               = 1'b0;
            end else begin
                dcnt = dcnt - 1;
            end
        end else if (mif.inst_req_o) begin
            if (acnt >= addr_delay) begin
                mif.inst_addr_ok_i = 1'b1;
                busy     = 1'b1;
                dcnt     = data_delay;
                cur_addr = mif.inst_addr_o;
                req_log.push_back(mif.inst_addr_o);
                acnt     = 0;
            end else begin
                acnt = acnt + 1;
            end
        end else begin
            acnt = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // waits for a valid ID output, optionally at a given pc
    task automatic wait_id(input string tag, input bit match_pc, input logic [31:0] pc);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (mif.id_valid_o && (!match_pc || mif.id_pc_o == pc)) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic do_flush(input logic [31:0] target);
        @(negedge clk);
        mif.exc_flush_i = 1'b1;
        mif.exc_pc_i    = target;
        @(negedge clk);
        mif.exc_flush_i = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        @(negedge clk);
        mif.redirect_i    = 1'b1;
        mif.redirect_pc_i = target;
        @(negedge clk);
        mif.redirect_i    = 1'b0;
    endtask

    // delay-slot redirect from a branch at 0x100 to 0x200
    task automatic branch_test(input string tag, input int a_delay);
        int n;
        addr_delay = a_delay;
        data_delay = 0;
        do_flush(32'h0000_0100);
        wait_id({tag, "_br_in_id"}, 1'b1, 32'h0000_0100);
        n = req_log.size();
        do_redirect(32'h0000_0200);
        repeat (16) step();
        check({tag, "_slot"}, log_at(n), 32'h0000_0104);
        check({tag, "_target"}, log_at(n + 1), 32'h0000_0200);
        addr_delay = 0;
    endtask

    initial begin
        int          n;
        int          stall_cnt;
        int          req_cnt;
        bit          found;
        logic [31:0] prev_instr;
        logic [31:0] prev_pc;

        n_checks = 0;
        n_fail   = 0;
        data_delay = 0;
        addr_delay = 0;
        dcnt = 0;
        acnt = 0;
        busy = 1'b0;
        cur_addr = '0;
        override_en = 1'b0;
        override_data = '0;
        mif.inst_addr_ok_i = 1'b0;
        mif.inst_data_ok_i = 1'b0;
        mif.inst_rdata_i   = '0;
        mif.id_stall_i     = 1'b0;
        mif.redirect_i     = 1'b0;
        mif.redirect_pc_i  = '0;
        mif.exc_flush_i    = 1'b0;
        mif.exc_pc_i       = '0;
        rst_n = 1'b0;

        repeat (3) step();
        check("rst_req", 32'(mif.inst_req_o), 32'd0);
        check("rst_valid", 32'(mif.id_valid_o), 32'd0);
        check("rst_instr", mif.id_instr_o, 32'h0000_0000);
        check("rst_pc", mif.id_pc_o, 32'h0000_0000);
        check("rst_pc4", mif.id_pc4_o, 32'h0000_0000);
        check("rst_adel", 32'(mif.id_adel_o), 32'd0);
        check("rst_stall", 32'(mif.if_stall_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // first two fetches after reset
        wait_id("t1_first", 1'b0, '0);
        check("t1_addr0", log_at(0), 32'hBFC0_0000);
        check("t1_pc", mif.id_pc_o, 32'hBFC0_0000);
        check("t1_pc4", mif.id_pc4_o, 32'hBFC0_0004);
        check("t1_instr", mif.id_instr_o, mem_word(32'hBFC0_0000));
        wait_id("t1_second", 1'b0, '0);
        check("t1_addr1", log_at(1), 32'hBFC0_0004);
        check("t1_pc_2", mif.id_pc_o, 32'hBFC0_0004);

        // slow memory: stall, bubbles, single outstanding request
        data_delay = 3;
        n = req_log.size();
        stall_cnt = 0;
        req_cnt = 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (mif.id_valid_o) begin
                found = 1'b1;
            end else begin
                if (mif.if_stall_o) stall_cnt++;
                if (mif.inst_req_o) req_cnt++;
            end
        end
        check("t2_found", 32'(found), 32'd1);
        check("t2_stall_cycles", 32'(stall_cnt), 32'd4);
        check("t2_req_in_wait", 32'(req_cnt), 32'd0);
        check("t2_one_request", 32'(req_log.size()), 32'(n + 1));
        check("t2_pc", mif.id_pc_o, 32'hBFC0_0008);

        // delay slot, slot accepted with redirect / slot accepted later
        branch_test("t3a", 0);
        branch_test("t3b", 2);

        // decode stall while data returns
        data_delay = 0;
        wait_id("t4_pre", 1'b0, '0);
        prev_instr = mif.id_instr_o;
        prev_pc    = mif.id_pc_o;
        @(negedge clk);
        mif.id_stall_i = 1'b1;
        override_data  = 32'hDEAD_BEEF;
        override_en    = 1'b1;
        repeat (6) step();
        check("t4_frozen_instr", mif.id_instr_o, prev_instr);
        check("t4_frozen_pc", mif.id_pc_o, prev_pc);
        check("t4_frozen_valid", 32'(mif.id_valid_o), 32'd1);
        check("t4_hold_no_stall", 32'(mif.if_stall_o), 32'd0);
        check("t4_hold_no_req", 32'(mif.inst_req_o), 32'd0);
        @(negedge clk);
        mif.id_stall_i = 1'b0;
        step();
        check("t4_instr", mif.id_instr_o, 32'hDEAD_BEEF);
        check("t4_pc", mif.id_pc_o, prev_pc + 32'd4);
        check("t4_valid", 32'(mif.id_valid_o), 32'd1);

        // flush while waiting on memory
        data_delay = 3;
        n = req_log.size();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (req_log.size() > n) found = 1'b1;
        end
        check("t5_accept", 32'(found), 32'd1);
        @(negedge clk);
        mif.exc_flush_i = 1'b1;
        mif.exc_pc_i    = 32'hBFC0_0380;
        @(negedge clk);
        mif.exc_flush_i = 1'b0;
        #2;
        check("t5_drop_stall", 32'(mif.if_stall_o), 32'd1);
        check("t5_drop_valid", 32'(mif.id_valid_o), 32'd0);
        wait_id("t5_resume", 1'b0, '0);
        check("t5_pc", mif.id_pc_o, 32'hBFC0_0380);
        check("t5_instr", mif.id_instr_o, mem_word(32'hBFC0_0380));
        check("t5_addr", log_at(n + 1), 32'hBFC0_0380);

        // pc wraps at the top of the address space
        data_delay = 0;
        do_flush(32'hFFFF_FFFC);
        wait_id("t6_top", 1'b1, 32'hFFFF_FFFC);
        check("t6_pc4_wrap", mif.id_pc4_o, 32'h0000_0000);
        wait_id("t6_next", 1'b0, '0);
        check("t6_pc_wrap", mif.id_pc_o, 32'h0000_0000);

        // jr to a misaligned target
        do_flush(32'h0000_0100);
        wait_id("t7_br_in_id", 1'b1, 32'h0000_0100);
        n = req_log.size();
        do_redirect(32'h0000_1002);
`ifdef IF_ADDR_EXC_EN
        repeat (12) step();
        check("t7_slot", log_at(n), 32'h0000_0104);
        check("t7_no_request", 32'(req_log.size()), 32'(n + 1));
        check("t7_req_low", 32'(mif.inst_req_o), 32'd0);
        check("t7_adel", 32'(mif.id_adel_o), 32'd1);
        check("t7_adel_pc", mif.id_pc_o, 32'h0000_1002);
        check("t7_adel_valid", 32'(mif.id_valid_o), 32'd1);
        check("t7_adel_instr", mif.id_instr_o, 32'h0000_0000);
        do_flush(32'hBFC0_0380);
        wait_id("t7_resume", 1'b0, '0);
        check("t7_resume_addr", log_at(n + 1), 32'hBFC0_0380);
        check("t7_resume_adel", 32'(mif.id_adel_o), 32'd0);
`else
        wait_id("t7_aligned_fetch", 1'b1, 32'h0000_1000);
        check("t7_slot", log_at(n), 32'h0000_0104);
        check("t7_aligned_addr", log_at(n + 1), 32'h0000_1000);
        check("t7_adel_tied", 32'(mif.id_adel_o), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
